ps2_rtc_cmd_decoder: RTL and testbench

Parametrised PS/2 scan-code-set-2 command decoder driving the RTC control path. It consumes one byte per key_valid strobe from the PS/2 receiver and parses the E0 (extended) and F0 (break) prefixes. Held-key typematic repeats are suppressed. Recognised keys become registered, width-controlled push-button pulses, toggle flags and a mode selector for the RTC controller FSM. Outputs are fully registered and replace the combinational key-to-control decode.

---
 rtl/ps2_rtc_cmd_decoder.sv | 113 +++++++++++
 tb/tb_ps2_rtc_cmd_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rtc_cmd_decoder.sv
// ps2_rtc_cmd_decoder: PS/2 set-2 scan-code parser driving registered RTC control pulses, flags and mode.
module ps2_rtc_cmd_decoder #(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 100000,
  parameter int REPEAT_FILTER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic [2:0] mode,
  output logic       timer_en,
  output logic       fmt_24h,
  output logic       pm_flag,
  output logic       pb_program,
  output logic       pb_up,
  output logic       pb_down,
  output logic       pb_left,
  output logic       pb_right,
  output logic       cmd_valid,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int PWW = $clog2(PULSE_W + 1);
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state, state_next;
  logic [TW-1:0] tcnt;
  logic [PWW-1:0] pcnt;
  logic [8:0] held, key;
  logic held_valid, timeout, make_ev, brk_ev, ext, drop, known, is_r, fmt_tgl, pm_tgl, apply, bad;
  logic [4:0] pb, pb_sel;
  logic [2:0] mode_sel;
  assign {pb_program, pb_right, pb_left, pb_down, pb_up} = pb;
  assign timeout = state != IDLE && !key_valid && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (timeout) state_next = IDLE;
    else if (key_valid)
      case (state)
        IDLE:    state_next = key_code == 8'hE0 ? GOT_E0 : key_code == 8'hF0 ? GOT_F0 : IDLE;
        GOT_E0:  state_next = key_code == 8'hF0 ? GOT_E0F0 : key_code == 8'hE0 ? GOT_E0 : IDLE;
        GOT_F0:  state_next = key_code == 8'hF0 ? GOT_F0 : IDLE;
        default: state_next = IDLE;
      endcase
  end
  always_comb begin
    make_ev = key_valid && (state == IDLE || state == GOT_E0) && key_code != 8'hE0 && key_code != 8'hF0;
    brk_ev = key_valid && ((state == GOT_F0 && key_code != 8'hF0) || state == GOT_E0F0);
    ext = state == GOT_E0 || state == GOT_E0F0;
    key = {ext, key_code};
    drop = REPEAT_FILTER != 0 && held_valid && held == key;
    pb_sel = '0;
    mode_sel = mode;
    fmt_tgl = 1'b0;
    pm_tgl = 1'b0;
    is_r = 1'b0;
    known = 1'b1;
    case (key)
      9'h01D, 9'h175: pb_sel = 5'b00001;
      9'h01B, 9'h172: pb_sel = 5'b00010;
      9'h01C, 9'h16B: pb_sel = 5'b00100;
      9'h023, 9'h174: pb_sel = 5'b01000;
      9'h04D:         pb_sel = 5'b10000;
      9'h02B:         fmt_tgl = 1'b1;
      9'h02A:         pm_tgl = 1'b1;
      9'h024:         mode_sel = 3'b010;
      9'h043:         mode_sel = 3'b001;
      9'h02C:         mode_sel = 3'b000;
      9'h02D: begin
        mode_sel = 3'b100;
        is_r = 1'b1;
      end
      default:        known = 1'b0;
    endcase
    apply = make_ev && !drop && known;
    bad = make_ev && !drop && !known;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      pcnt <= '0;
      pb <= '0;
      held <= '0;
      held_valid <= 1'b0;
      mode <= 3'b000;
      timer_en <= 1'b0;
      fmt_24h <= 1'b0;
      pm_flag <= 1'b0;
      cmd_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      tcnt <= (state == IDLE || key_valid || timeout) ? '0 : tcnt + TW'(1);
      cmd_valid <= apply;
      err <= bad || timeout;
      held_valid <= apply ? 1'b1 : (brk_ev && held_valid && held == key) ? 1'b0 : held_valid;
      if (apply) begin
        held <= key;
        mode <= mode_sel;
        timer_en <= !is_r;
        fmt_24h <= !is_r && (fmt_24h ^ fmt_tgl);
        pm_flag <= !is_r && (pm_flag ^ pm_tgl);
      end
      // a new button command preempts whatever pulse is running
      if (apply && pb_sel != '0) begin
        pb <= pb_sel;
        pcnt <= PWW'(PULSE_W - 1);
      end else if (pcnt != '0) pcnt <= pcnt - PWW'(1);
      else pb <= '0;
    end
endmodule

// File: tb/tb_ps2_rtc_cmd_decoder.sv
// tb_ps2_rtc_cmd_decoder: scoreboard bench for the PS/2 RTC command decoder.
module tb_ps2_rtc_cmd_decoder;
  localparam int PW = 4;
  localparam int TO = 20;
  logic clk = 0, reset = 1, key_valid = 0;
  logic [7:0] key_code = 0;
  logic [2:0] mode;
  logic timer_en, fmt_24h, pm_flag, pb_program, pb_up, pb_down, pb_left, pb_right, cmd_valid, err;
  ps2_rtc_cmd_decoder #(.PULSE_W(PW), .TIMEOUT(TO), .REPEAT_FILTER(1)) dut (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .mode(mode), .timer_en(timer_en), .fmt_24h(fmt_24h), .pm_flag(pm_flag),
    .pb_program(pb_program), .pb_up(pb_up), .pb_down(pb_down), .pb_left(pb_left),
    .pb_right(pb_right), .cmd_valid(cmd_valid), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic cv, er;
    logic [2:0] mode;
    logic timer, fmt, pm;
    logic [4:0] pb;
    logic pbchk;
  } rec_t;
  rec_t sb[$];
  int exp_len[$];
  int n_tests = 0, n_fail = 0, cyc = 0, tstart = -1000, run = 0;
  logic [2:0] m_mode = 0;
  logic m_timer = 0, m_fmt = 0, m_pm = 0, held_v = 0;
  logic [8:0] held = 0;
  logic [4:0] pb_now, prev_pb = 0;
  assign pb_now = {pb_program, pb_right, pb_left, pb_down, pb_up};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_pb"}, {27'b0, pb_now}, 0);
    chk({p, "_mode"}, {29'b0, mode}, 0);
    chk({p, "_timer"}, {31'b0, timer_en}, 0);
    chk({p, "_fmt"}, {31'b0, fmt_24h}, 0);
    chk({p, "_pm"}, {31'b0, pm_flag}, 0);
    chk({p, "_evt"}, {30'b0, cmd_valid, err}, 0);
  endtask
  task automatic scoreboard();
    rec_t r;
    if (sb.size() == 0) chk("evt_extra", {30'b0, cmd_valid, err}, 0);
    else begin
      r = sb.pop_front();
      chk("cmd_valid", {31'b0, cmd_valid}, {31'b0, r.cv});
      chk("err", {31'b0, err}, {31'b0, r.er});
      chk("mode", {29'b0, mode}, {29'b0, r.mode});
      chk("timer_en", {31'b0, timer_en}, {31'b0, r.timer});
      chk("fmt_24h", {31'b0, fmt_24h}, {31'b0, r.fmt});
      chk("pm_flag", {31'b0, pm_flag}, {31'b0, r.pm});
      if (r.pbchk) chk("pb", {27'b0, pb_now}, {27'b0, r.pb});
    end
  endtask
  always @(negedge clk)
    if (reset) begin
      prev_pb <= 0;
      run <= 0;
    end else begin
      if (pb_now != 0) chk("pb_onehot", $countones(pb_now), 1);
      if (prev_pb != 0 && pb_now != prev_pb) begin
        if (exp_len.size() == 0) chk("pulse_extra", run, 0);
        else chk("pulse_len", run, exp_len.pop_front());
      end
      run <= pb_now == 0 ? 0 : pb_now != prev_pb ? 1 : run + 1;
      prev_pb <= pb_now;
      if (cmd_valid || err) scoreboard();
    end
  task automatic send(input logic [7:0] b);
    key_code = b;
    key_valid = 1;
    @(posedge clk);
    #1 key_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic cv, input logic er, input logic [4:0] pb);
    rec_t r;
    r.cv = cv; r.er = er; r.mode = m_mode; r.timer = m_timer;
    r.fmt = m_fmt; r.pm = m_pm; r.pb = pb; r.pbchk = pb != 0;
    sb.push_back(r);
  endtask
  task automatic make(input logic ext, input logic [7:0] c);
    logic [8:0] k;
    logic [4:0] p;
    logic rec;
    k = {ext, c};
    p = 0;
    rec = 1;
    if (!(held_v && held == k)) begin
      case (k)
        9'h01D, 9'h175: p = 5'b00001;
        9'h01B, 9'h172: p = 5'b00010;
        9'h01C, 9'h16B: p = 5'b00100;
        9'h023, 9'h174: p = 5'b01000;
        9'h04D: p = 5'b10000;
        9'h02B: m_fmt = ~m_fmt;
        9'h02A: m_pm = ~m_pm;
        9'h024: m_mode = 3'b010;
        9'h043: m_mode = 3'b001;
        9'h02C: m_mode = 3'b000;
        9'h02D: begin m_mode = 3'b100; m_fmt = 0; m_pm = 0; end
        default: rec = 0;
      endcase
      if (rec) begin
        m_timer = k != 9'h02D;
        held = k;
        held_v = 1;
      end
      push(rec, !rec, p);
    end
    if (ext) send(8'hE0);
    send(c);
    if (p != 0) begin
      if (cyc - tstart < PW) exp_len[exp_len.size() - 1] = cyc - tstart;
      exp_len.push_back(PW);
      tstart = cyc;
    end
  endtask
  task automatic brk(input logic ext, input logic [7:0] c);
    if (ext) send(8'hE0);
    send(8'hF0);
    send(c);
    if (held_v && held == {ext, c}) held_v = 0;
  endtask
  task automatic model_reset();
    m_mode = 0; m_timer = 0; m_fmt = 0; m_pm = 0; held_v = 0; tstart = -1000;
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_zero("rst");
    make(0, 8'h1D); brk(0, 8'h1D); idle(6);
    make(1, 8'h75); make(1, 8'h75); idle(6);
    brk(1, 8'h75); make(1, 8'h75); idle(6); brk(1, 8'h75);
    make(0, 8'h2B); brk(0, 8'h2B); make(0, 8'h2A); brk(0, 8'h2A);
    make(0, 8'h2D); brk(0, 8'h2D);
    push(0, 1, 0);
    send(8'hE0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < TO + 10);
    chk("timeout_lat", n, TO + 1);
    @(negedge clk);
    chk("timeout_once", {31'b0, err}, 0);
    make(0, 8'h1B); idle(6); brk(0, 8'h1B);
    make(0, 8'h1C); idle(1); make(0, 8'h23); idle(6);
    brk(0, 8'h1C); brk(0, 8'h23);
    make(0, 8'h1D); make(0, 8'h2B); idle(6); brk(0, 8'h2B);
    make(0, 8'h55); make(0, 8'h55); idle(2);
    make(0, 8'h1B); idle(2);
    #2 reset = 1;
    #1 chk_zero("rst_mid");
    model_reset();
    exp_len.delete(exp_len.size() - 1);
    @(posedge clk);
    #1 reset = 0;
    send(8'hE0);
    #2 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    make(0, 8'h1B); idle(8);
    chk("sb_left", sb.size(), 0);
    chk("len_left", exp_len.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
